// File: rtl/sid_spi_regs.sv
// sid_spi_regs: SPI mode-0 slave that programs the SID voice-control bus.
// Every SPI pin is oversampled in the clk domain; sclk is never used as a clock.
// A frame is 16 bits while cs_n is low: a command byte (bit7 = read, bits6:0 =
// address) followed by a data byte. The 16-bit words are written through
// shadow bytes, so each word changes in one step.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   sclk       SPI clock from the host (idle low, asynchronous)
//   cs_n       SPI chip select, active low (asynchronous)
//   mosi       SPI data in, MSB first
//   miso       SPI read data out, MSB first, low when no read data is shifting
//   frequency  committed 16-bit voice frequency word
//   duration   committed 16-bit voice duration word
//   attack     committed attack byte
//   sustain    committed sustain byte
//   waveform   committed waveform byte
//   frame_err  one-cycle pulse when a frame is aborted part-way
module sid_spi_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [15:0] frequency,
  output logic [15:0] duration,
  output logic [7:0]  attack,
  output logic [7:0]  sustain,
  output logic [7:0]  waveform,
  output logic        frame_err
);

  localparam int unsigned ByteW  = 8;
  localparam int unsigned WordW  = 16;
  localparam int unsigned AddrW  = 7;
  localparam int unsigned CntW   = 5;
  localparam int unsigned SrW    = WordW - 1;

  localparam logic [CntW-1:0] BcntZero    = CntW'(0);
  localparam logic [CntW-1:0] BcntCmdLast = CntW'(7);
  localparam logic [CntW-1:0] BcntDatLast = CntW'(15);
  localparam logic [CntW-1:0] BcntFull    = CntW'(16);

  localparam logic [AddrW-1:0] AddrFreqLo = AddrW'(0);
  localparam logic [AddrW-1:0] AddrFreqHi = AddrW'(1);
  localparam logic [AddrW-1:0] AddrDurLo  = AddrW'(2);
  localparam logic [AddrW-1:0] AddrDurHi  = AddrW'(3);
  localparam logic [AddrW-1:0] AddrAttack = AddrW'(4);
  localparam logic [AddrW-1:0] AddrSustn  = AddrW'(5);
  localparam logic [AddrW-1:0] AddrWave   = AddrW'(6);

  // Synchronisers: sclk has an extra stage for edge detection, cs_n keeps
  // its previous synchronised value for deselect-edge detection.
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] cs_sync_q,   cs_sync_d;
  logic       cs_prev_q,   cs_prev_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  // Frame state.
  logic             armed_q,     armed_d;
  logic [CntW-1:0]  bcnt_q,      bcnt_d;
  logic [SrW-1:0]   sr_q,        sr_d;
  logic [ByteW-1:0] osr_q,       osr_d;
  logic             rd_active_q, rd_active_d;
  logic             miso_q,      miso_d;
  logic             frame_err_q, frame_err_d;

  // Shadow bytes and committed voice registers.
  logic [ByteW-1:0] freq_sh_q,   freq_sh_d;
  logic [ByteW-1:0] dur_sh_q,    dur_sh_d;
  logic [WordW-1:0] freq_q,      freq_d;
  logic [WordW-1:0] dur_q,       dur_d;
  logic [ByteW-1:0] attack_q,    attack_d;
  logic [ByteW-1:0] sustain_q,   sustain_d;
  logic [ByteW-1:0] waveform_q,  waveform_d;

  // Decoded events.
  logic             sclk_rise;
  logic             sclk_fall;
  logic             cs_hi;
  logic             cs_rise;
  logic             shift_en;
  logic [WordW-1:0] sr_shift;
  logic             load_rd;
  logic             wr_commit;
  logic [AddrW-1:0] wr_addr;
  logic [ByteW-1:0] wr_data;
  logic [AddrW-1:0] rd_addr;
  logic [ByteW-1:0] rd_byte;

  // Edge and frame-event decode.
  always_comb begin
    sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    cs_hi     = cs_sync_q[1];
    cs_rise   = cs_hi & ~cs_prev_q;
    // Deselect has priority over a simultaneous rise; bits past 16 are ignored.
    // Nothing is counted until cs_n has been seen high since reset, so a
    // frame interrupted by reset is discarded.
    shift_en  = armed_q & ~cs_hi & sclk_rise & (bcnt_q != BcntFull);
    sr_shift  = {sr_q, mosi_sync_q[1]};
    rd_addr   = sr_shift[AddrW-1:0];
    load_rd   = shift_en & (bcnt_q == BcntCmdLast) & sr_shift[ByteW-1];
    wr_addr   = sr_shift[WordW-2:ByteW];
    wr_data   = sr_shift[ByteW-1:0];
    wr_commit = shift_en & (bcnt_q == BcntDatLast) & ~sr_shift[WordW-1];
  end

  // Read-back mux: 16-bit words return the committed bytes, not the shadows.
  always_comb begin
    rd_byte = '0;
    case (rd_addr)
      AddrFreqLo: rd_byte = freq_q[ByteW-1:0];
      AddrFreqHi: rd_byte = freq_q[WordW-1:ByteW];
      AddrDurLo:  rd_byte = dur_q[ByteW-1:0];
      AddrDurHi:  rd_byte = dur_q[WordW-1:ByteW];
      AddrAttack: rd_byte = attack_q;
      AddrSustn:  rd_byte = sustain_q;
      AddrWave:   rd_byte = waveform_q;
      default:    rd_byte = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    cs_sync_d   = {cs_sync_q[0], cs_n};
    cs_prev_d   = cs_sync_q[1];
    mosi_sync_d = {mosi_sync_q[0], mosi};

    armed_d     = armed_q;
    bcnt_d      = bcnt_q;
    sr_d        = sr_q;
    osr_d       = osr_q;
    rd_active_d = rd_active_q;
    miso_d      = miso_q;
    frame_err_d = 1'b0;
    freq_sh_d   = freq_sh_q;
    dur_sh_d    = dur_sh_q;
    freq_d      = freq_q;
    dur_d       = dur_q;
    attack_d    = attack_q;
    sustain_d   = sustain_q;
    waveform_d  = waveform_q;

    if (cs_hi) begin
      armed_d     = 1'b1;
      bcnt_d      = BcntZero;
      rd_active_d = 1'b0;
      miso_d      = 1'b0;
      // A frame that stopped neither before its first bit nor at 16 bits.
      if (cs_rise && (bcnt_q != BcntZero) && (bcnt_q != BcntFull)) begin
        frame_err_d = 1'b1;
      end
    end else begin
      if (shift_en) begin
        sr_d   = sr_shift[SrW-1:0];
        bcnt_d = bcnt_q + CntW'(1);
      end

      if (load_rd) begin
        osr_d       = rd_byte;
        rd_active_d = 1'b1;
      end

      // Present the next read bit on each falling sclk; host samples on rise.
      if (sclk_fall) begin
        if (rd_active_q) begin
          miso_d = osr_q[ByteW-1];
          osr_d  = {osr_q[ByteW-2:0], 1'b0};
        end else begin
          miso_d = 1'b0;
        end
      end

      if (wr_commit) begin
        case (wr_addr)
          AddrFreqLo: freq_sh_d  = wr_data;
          AddrFreqHi: freq_d     = {wr_data, freq_sh_q};
          AddrDurLo:  dur_sh_d   = wr_data;
          AddrDurHi:  dur_d      = {wr_data, dur_sh_q};
          AddrAttack: attack_d   = wr_data;
          AddrSustn:  sustain_d  = wr_data;
          AddrWave:   waveform_d = wr_data;
          default: ;
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      cs_prev_q   <= 1'b0;
      mosi_sync_q <= '0;
      armed_q     <= 1'b0;
      bcnt_q      <= '0;
      sr_q        <= '0;
      osr_q       <= '0;
      rd_active_q <= 1'b0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
      freq_sh_q   <= '0;
      dur_sh_q    <= '0;
      freq_q      <= '0;
      dur_q       <= '0;
      attack_q    <= '0;
      sustain_q   <= '0;
      waveform_q  <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      cs_prev_q   <= cs_prev_d;
      mosi_sync_q <= mosi_sync_d;
      armed_q     <= armed_d;
      bcnt_q      <= bcnt_d;
      sr_q        <= sr_d;
      osr_q       <= osr_d;
      rd_active_q <= rd_active_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
      freq_sh_q   <= freq_sh_d;
      dur_sh_q    <= dur_sh_d;
      freq_q      <= freq_d;
      dur_q       <= dur_d;
      attack_q    <= attack_d;
      sustain_q   <= sustain_d;
      waveform_q  <= waveform_d;
    end
  end

  assign miso      = miso_q;
  assign frequency = freq_q;
  assign duration  = dur_q;
  assign attack    = attack_q;
  assign sustain   = sustain_q;
  assign waveform  = waveform_q;
  assign frame_err = frame_err_q;

endmodule
